// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row drive, 2-flop column sync, per-scan ghost rejection, scan-level debounce.
// Accept lands on the edge ending a full scan; key_valid/key_ack handshake never stalls scanning (overrun flags lost codes).
module keypad_scan #(
    parameter int SCAN_TICKS     = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       overrun
);
    localparam int            TW        = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [3:0]    DEB       = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, REL_DEB} state_t;

    state_t        state, state_d;
    logic [3:0]    count, count_d, count_inc;
    logic [3:0]    cand, cand_d;
    logic [TW-1:0] tick;
    logic [1:0]    ridx;
    logic [3:0]    col_s1, col_s2;
    logic [1:0]    seen_cnt;
    logic [3:0]    seen_code;
    logic          row_end, scan_end;
    logic          row_hit;
    logic [1:0]    hit_col;
    logic          res_vld;
    logic [3:0]    res_code;
    logic          accept, release_k;

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'h0;  4'hD: k = 4'hF;  4'hE: k = 4'hE;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign row_end   = (tick == TICK_LAST);
    assign scan_end  = row_end && (ridx == 2'd3);
    assign count_inc = count + 4'd1;

    // A row contributes a key only when exactly one column line is low.
    always_comb begin
        row_hit = 1'b0;
        hit_col = 2'd0;
        case (col_s2)
            4'b1110: begin row_hit = 1'b1; hit_col = 2'd0; end
            4'b1101: begin row_hit = 1'b1; hit_col = 2'd1; end
            4'b1011: begin row_hit = 1'b1; hit_col = 2'd2; end
            4'b0111: begin row_hit = 1'b1; hit_col = 2'd3; end
            default: begin row_hit = 1'b0; hit_col = 2'd0; end
        endcase
    end

    // Scan result folds in the row-3 sample taken on this same cycle.
    always_comb begin
        res_vld  = 1'b0;
        res_code = seen_code;
        if (seen_cnt == 2'd0 && row_hit) begin
            res_vld  = 1'b1;
            res_code = keymap(2'd3, hit_col);
        end else if (seen_cnt == 2'd1 && !row_hit) begin
            res_vld  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_s1    <= 4'hF;
            col_s2    <= 4'hF;
            tick      <= '0;
            ridx      <= 2'd0;
            row       <= 4'b1110;
            seen_cnt  <= 2'd0;
            seen_code <= 4'h0;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
            if (row_end) begin
                tick <= '0;
                ridx <= ridx + 2'd1;
                row  <= {row[2:0], row[3]};
                if (ridx == 2'd3) begin
                    seen_cnt  <= 2'd0;
                    seen_code <= 4'h0;
                end else if (row_hit) begin
                    seen_cnt  <= (seen_cnt == 2'd0) ? 2'd1 : 2'd2;
                    seen_code <= keymap(ridx, hit_col);
                end
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state;
        count_d   = count;
        cand_d    = cand;
        accept    = 1'b0;
        release_k = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (res_vld) begin
                        cand_d  = res_code;
                        count_d = 4'd1;
                        if (DEB == 4'd1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = PRESS_DEB;
                        end
                    end
                end
                PRESS_DEB: begin
                    if (!res_vld) begin
                        count_d = 4'd0;
                        state_d = IDLE;
                    end else if (res_code == cand) begin
                        count_d = count_inc;
                        if (count_inc == DEB) begin
                            accept  = 1'b1;
                            state_d = HELD;
                        end
                    end else begin
                        cand_d  = res_code;
                        count_d = 4'd1;
                    end
                end
                HELD: begin
                    if (!(res_vld && res_code == cand)) begin
                        if (DEB == 4'd1) begin
                            count_d   = 4'd0;
                            release_k = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            count_d = 4'd1;
                            state_d = REL_DEB;
                        end
                    end
                end
                default: begin
                    if (res_vld && res_code == cand) begin
                        count_d = 4'd0;
                        state_d = HELD;
                    end else if (count_inc == DEB) begin
                        count_d   = 4'd0;
                        release_k = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        count_d = count_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 4'd0;
            cand      <= 4'h0;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state <= state_d;
            count <= count_d;
            cand  <= cand_d;
            if (accept) begin
                key       <= cand_d;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                if (key_valid && !key_ack) overrun <= 1'b1;
            end else if (key_valid && key_ack) begin
                key_valid <= 1'b0;
            end
            if (release_k) key_held <= 1'b0;
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Keypad scanner bench: ideal keypad matrix, scan-level reference model, per-cycle compare plus directed literal checks.
module tb_keypad_scan;
    localparam int ST   = 4;
    localparam int DEB  = 2;
    localparam int SCAN = 4 * ST;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_ack = 1'b0;
    logic [3:0]  row, col, key;
    logic        key_valid, key_held, overrun;
    logic [15:0] pressed = 16'h0;

    int n_tests = 0;
    int n_fail  = 0;

    int KEYMAP [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    always #5 clk = ~clk;

    keypad_scan #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key(key),
        .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held), .overrun(overrun)
    );

    // Ideal switch matrix: a pressed key shorts its column to the driven row.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (row[r] == 1'b0)
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) col[c] = 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model
    int          m_cyc = 0;
    logic [3:0]  m_key = 4'h0;
    bit          m_kv = 0, m_held = 0, m_ov = 0;
    int          m_hcode = -1;
    int          press_q[$];
    bit          rel_q[$];
    bit          started = 0;

    function automatic int scan_result(input logic [15:0] p);
        int seen = 0;
        int code = -1;
        for (int r = 0; r < 4; r++) begin
            int n = 0;
            int ch = 0;
            for (int c = 0; c < 4; c++)
                if (p[r*4+c]) begin n++; ch = c; end
            if (n == 1) begin seen++; code = KEYMAP[r*4+ch]; end
        end
        return (seen == 1) ? code : -1;
    endfunction

    always @(posedge clk) begin : model
        bit acc, rel;
        int res, nc;
        started = 1;
        acc = 0; rel = 0; nc = 0;
        if (!rst_n) begin
            m_cyc = 0; m_key = 4'h0; m_kv = 0; m_held = 0; m_ov = 0; m_hcode = -1;
            press_q.delete(); rel_q.delete();
        end else begin
            if (m_cyc % SCAN == SCAN - 1) begin
                res = scan_result(pressed);
                if (!m_held) begin
                    press_q.push_back(res);
                    if (press_q.size() > 16) void'(press_q.pop_front());
                    if (res >= 0 && press_q.size() >= DEB) begin
                        acc = 1;
                        for (int i = 0; i < DEB; i++)
                            if (press_q[press_q.size()-1-i] != res) acc = 0;
                    end
                    if (acc) begin nc = res; press_q.delete(); end
                end else begin
                    rel_q.push_back(res != m_hcode);
                    if (rel_q.size() > 16) void'(rel_q.pop_front());
                    if (rel_q.size() >= DEB) begin
                        rel = 1;
                        for (int i = 0; i < DEB; i++)
                            if (!rel_q[rel_q.size()-1-i]) rel = 0;
                    end
                    if (rel) rel_q.delete();
                end
            end
            if (acc) begin
                if (m_kv && !key_ack) m_ov = 1;
                m_key = 4'(nc); m_kv = 1; m_held = 1; m_hcode = nc;
                rel_q.delete();
            end else if (m_kv && key_ack) begin
                m_kv = 0;
            end
            if (rel) m_held = 0;
            m_cyc++;
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] er;
        if (started) begin
            er = 4'hF;
            er[(m_cyc / ST) % 4] = 1'b0;
            chk("row", row, er);
            chk("key_valid", key_valid, m_kv);
            chk("key_held", key_held, m_held);
            chk("overrun", overrun, m_ov);
            chk("key", key, m_key);
        end
    end

    task automatic scan_start();
        while (m_cyc % SCAN != 0) begin
            @(negedge clk);
            key_ack = 1'b0;
        end
    endtask

    task automatic press(input logic [15:0] mask, input int n, input bit ack_last);
        scan_start();
        pressed = mask;
        repeat (SCAN * n - 1) @(negedge clk);
        if (ack_last) key_ack = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        key_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_row", row, 4'b1110);
        chk("rst_key", key, 4'h0);
        chk("rst_kv", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        chk("rst_ov", overrun, 1'b0);
        rst_n = 1'b1;
    endtask

    localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0002, K3 = 16'h0004, KA = 16'h0008;
    localparam logic [15:0] K5 = 16'h0020, K8 = 16'h0200;

    initial begin : stim
        logic [3:0] rows_exp [4];
        rows_exp = '{4'hE, 4'hD, 4'hB, 4'h7};

        do_reset();
        // Idle scanning: row walk
        for (int i = 0; i < 3 * SCAN; i++) begin
            chk("row_walk", row, rows_exp[(i / ST) % 4]);
            chk("idle_kv", key_valid, 1'b0);
            @(negedge clk);
        end

        // Press 8 and hold
        press(K8, 2, 0);
        chk("k8_before", key_valid, 1'b0);
        settle();
        chk("k8_kv", key_valid, 1'b1);
        chk("k8_key", key, 4'h8);
        chk("k8_held", key_held, 1'b1);
        ack_pulse();
        chk("k8_ack_kv", key_valid, 1'b0);
        chk("k8_ack_key", key, 4'h8);
        press(16'h0, 2, 0);
        settle();
        chk("k8_release", key_held, 1'b0);

        // Bouncy 5
        press(K5, 1, 0);
        press(16'h0, 1, 0);
        press(K5, 1, 0);
        settle();
        chk("k5_no_accept", key_valid, 1'b0);
        press(K5, 1, 0);
        settle();
        chk("k5_kv", key_valid, 1'b1);
        chk("k5_key", key, 4'h5);
        press(K5, 2, 0);
        settle();
        chk("k5_single_accept_ov", overrun, 1'b0);
        ack_pulse();
        press(16'h0, 2, 0);

        // Ghost/multi-key rejection
        press(K1 | K2, 2, 0);
        settle();
        chk("k12_reject", key_valid, 1'b0);
        press(K1, 1, 0);
        settle();
        chk("k1_one_scan", key_valid, 1'b0);
        press(K1, 1, 0);
        settle();
        chk("k1_kv", key_valid, 1'b1);
        chk("k1_key", key, 4'h1);
        ack_pulse();
        press(16'h0, 2, 0);

        // Accept coinciding with ack, then overrun
        press(K3, 2, 0);
        settle();
        chk("k3_key", key, 4'h3);
        press(16'h0, 2, 0);
        press(KA, 2, 1);
        settle();
        chk("kA_ack_key", key, 4'hA);
        chk("kA_ack_kv", key_valid, 1'b1);
        chk("kA_ack_ov", overrun, 1'b0);
        press(16'h0, 2, 0);
        press(K3, 2, 0);
        settle();
        chk("ovr_key", key, 4'h3);
        chk("ovr_kv", key_valid, 1'b1);
        chk("ovr_flag", overrun, 1'b1);

        // Reset mid-debounce and while held
        press(K8, 1, 0);
        repeat (5) @(negedge clk);
        do_reset();
        press(K8, 1, 0);
        settle();
        chk("rstdeb_one_scan", key_valid, 1'b0);
        press(K8, 1, 0);
        settle();
        chk("rstdeb_kv", key_valid, 1'b1);
        chk("rstdeb_key", key, 4'h8);
        do_reset();
        press(K8, 1, 0);
        settle();
        chk("rstheld_one_scan", key_held, 1'b0);
        press(K8, 1, 0);
        settle();
        chk("rstheld_held", key_held, 1'b1);
        press(16'h0, 2, 0);

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            logic [15:0] mask;
            int kind;
            kind = $urandom_range(0, 3);
            mask = 16'h0;
            if (kind == 1 || kind == 2) mask = 16'h1 << $urandom_range(0, 15);
            if (kind == 3) mask = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            press(mask, $urandom_range(1, 3), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) ack_pulse();
            if ($urandom_range(0, 19) == 0) do_reset();
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end
endmodule
